// File: rtl/run_controller_if.sv
// Memory read port and dump stream port of the run controller.
// master = run_controller side, slave = memory / dump consumer side.
interface run_controller_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [DATA_WIDTH-1:0] dump_data;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic                  dump_last;

  modport master (
    output mem_rd, mem_addr, dump_valid, dump_data, dump_addr, dump_last,
    input  mem_rdata, dump_ready
  );

  modport slave (
    input  mem_rd, mem_addr, dump_valid, dump_data, dump_addr, dump_last,
    output mem_rdata, dump_ready
  );
endinterface

// File: rtl/run_controller.sv
// Run-control and memory-dump sequencer: holds the CPU in reset for a boot
// window, runs it until leds[0] rises or the watchdog expires, then freezes
// the CPU and streams the first DUMP_WORDS data-memory words out.
module run_controller #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DUMP_WORDS  = 256,
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        done_in,
  output logic        cpu_reset,
  output logic        busy,
  output logic        finished,
  output logic        timed_out,
  output logic [31:0] cycle_count,
  run_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    DUMP_REQ,
    DUMP_WAIT,
    DUMP_OUT,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DUMP_WORDS - 1);
  localparam logic [31:0]           HOLD_LAST = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0]           WDOG_LAST = 32'(TIMEOUT - 1);

  state_t                state;
  logic                  done_prev;
  logic [31:0]           hold_cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  done_edge;
  logic                  wdog_hit;

  assign done_edge = done_in & ~done_prev;
  assign wdog_hit  = (TIMEOUT != 0) && (cycle_count == WDOG_LAST);

  // Stream handshake flags decoded from state/idx only, no input paths.
  assign bus.dump_valid = (state == DUMP_OUT);
  assign bus.dump_last  = (state == DUMP_OUT) && (idx == LAST_IDX);

  // Sequencer FSM; every other output is registered alongside the transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      done_prev     <= 1'b0;
      hold_cnt      <= '0;
      idx           <= '0;
      cpu_reset     <= 1'b1;
      busy          <= 1'b0;
      finished      <= 1'b0;
      timed_out     <= 1'b0;
      cycle_count   <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.dump_data <= '0;
      bus.dump_addr <= '0;
    end else begin
      done_prev <= done_in;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= HOLD;
            busy        <= 1'b1;
            finished    <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            hold_cnt    <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        RUN: begin
          if (cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
          end
          // A done edge in the same cycle as the watchdog takes priority.
          if (done_edge || wdog_hit) begin
            state        <= DUMP_REQ;
            cpu_reset    <= 1'b1;
            timed_out    <= ~done_edge;
            idx          <= '0;
            bus.mem_rd   <= 1'b1;
            bus.mem_addr <= '0;
          end
        end
        DUMP_REQ: begin
          bus.mem_rd <= 1'b0;
          state      <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          bus.dump_data <= bus.mem_rdata;
          bus.dump_addr <= idx;
          state         <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (bus.dump_ready) begin
            if (idx == LAST_IDX) begin
              state    <= DONE;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else begin
              idx          <= idx + 1'b1;
              bus.mem_addr <= idx + 1'b1;
              bus.mem_rd   <= 1'b1;
              state        <= DUMP_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: sequences complete runs, models the data memory,
// and checks the dump stream against a queue of expected words.
module tb_run_controller;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned WORDS = 4;
  localparam int unsigned BOOT  = 4;
  localparam int unsigned TOUT  = 50;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done_in;
  logic        cpu_reset;
  logic        busy;
  logic        finished;
  logic        timed_out;
  logic [31:0] cycle_count;

  int          checks   = 0;
  int          failures = 0;
  int          edge_n   = 0;
  int          rd_count = 0;
  logic        bp_arm   = 1'b0;
  logic        stall_pend = 1'b0;
  logic [DW-1:0] stall_data;
  logic [AW-1:0] stall_addr;
  logic [DW-1:0] mem [256];
  word_t       sb [$];

  run_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  run_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DUMP_WORDS (WORDS),
    .BOOT_CYCLES(BOOT),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done_in    (done_in),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .finished   (finished),
    .timed_out  (timed_out),
    .cycle_count(cycle_count),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Synchronous data memory: read data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cpu_reset"}, cpu_reset, 1);
    check_eq({tag, "_mem_rd"}, bus.mem_rd, 0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_dump_valid"}, bus.dump_valid, 0);
    check_eq({tag, "_dump_data"}, bus.dump_data, 0);
    check_eq({tag, "_dump_addr"}, bus.dump_addr, 0);
    check_eq({tag, "_dump_last"}, bus.dump_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_finished"}, finished, 0);
    check_eq({tag, "_timed_out"}, timed_out, 0);
    check_eq({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // Dump stream monitor: pops expected words on handshakes, checks stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (bus.mem_rd) rd_count++;
      if (bus.dump_valid) begin
        if (stall_pend) begin
          check_eq("stall_data", bus.dump_data, stall_data);
          check_eq("stall_addr", bus.dump_addr, stall_addr);
        end
        if (bus.dump_ready) begin
          if (sb.size() == 0) begin
            check_eq("sb_underflow", sb.size(), 1);
          end else begin
            word_t w;
            w = sb.pop_front();
            check_eq("dump_addr", bus.dump_addr, w.addr);
            check_eq("dump_data", bus.dump_data, w.data);
            check_eq("dump_last", bus.dump_last, w.last);
          end
          stall_pend = 1'b0;
        end else begin
          stall_pend = 1'b1;
          stall_data = bus.dump_data;
          stall_addr = bus.dump_addr;
        end
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  // Backpressure driver: holds dump_ready low for 5 cycles on word 2 when armed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_arm && bus.dump_valid && bus.dump_addr == 8'd2) begin
        bp_arm = 1'b0;
        bus.dump_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.dump_ready = 1'b1;
      end
    end
  end

  // One full run: done_at is the edge offset (from the start edge) where done_in
  // is first sampled high, 0 leaves it low. abort_word >= 0 resets mid-dump.
  task automatic do_run(input string tag, input int done_at, input logic [31:0] exp_cc,
                        input logic exp_to, input int exp_fin, input int abort_word);
    int exit_at;
    int n;
    int s_edge;
    exit_at = (done_at > 0) ? done_at : int'(BOOT + TOUT);
    for (int unsigned i = 0; i < WORDS; i++) begin
      word_t w;
      w.addr = AW'(i);
      w.data = mem[i];
      w.last = (i == WORDS - 1);
      sb.push_back(w);
    end
    rd_count = 0;
    @(posedge clk);
    #1;
    start   = 1'b1;
    done_in = 1'b0;
    @(posedge clk);
    #1;
    s_edge = edge_n;
    start  = 1'b0;
    check_eq({tag, "_busy_start"}, busy, 1);
    check_eq({tag, "_cc_clear"}, cycle_count, 0);
    check_eq({tag, "_fin_clear"}, finished, 0);
    check_eq({tag, "_to_clear"}, timed_out, 0);
    check_eq({tag, "_cpu_rst_hold0"}, cpu_reset, 1);
    for (int k = 1; k <= int'(BOOT); k++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_cpu_rst_boot"}, cpu_reset, (k < int'(BOOT)) ? 1 : 0);
    end
    repeat (exit_at - int'(BOOT) - 1) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_mem_rd_early"}, bus.mem_rd, 0);
    check_eq({tag, "_cpu_rst_run"}, cpu_reset, 0);
    if (done_at > 0) done_in = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_exit_edge"}, edge_n - s_edge, exit_at);
    check_eq({tag, "_mem_rd_first"}, bus.mem_rd, 1);
    check_eq({tag, "_mem_addr_first"}, bus.mem_addr, 0);
    check_eq({tag, "_cpu_rst_dump"}, cpu_reset, 1);
    check_eq({tag, "_cycle_count"}, cycle_count, exp_cc);
    check_eq({tag, "_timed_out"}, timed_out, exp_to);
    if (abort_word >= 0) begin
      n = 0;
      while (!(bus.dump_valid && bus.dump_addr == AW'(abort_word)) && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      check_eq({tag, "_abort_seen"}, n < 100, 1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals({tag, "_midreset"});
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_eq({tag, "_idle_after_rst"}, busy, 0);
      return;
    end
    n = 0;
    while (!finished && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_fin_latency"}, n, exp_fin);
    check_eq({tag, "_rd_count"}, rd_count, WORDS);
    check_eq({tag, "_sb_left"}, sb.size(), 0);
    check_eq({tag, "_busy_done"}, busy, 0);
    check_eq({tag, "_cpu_rst_done"}, cpu_reset, 1);
    check_eq({tag, "_cc_held"}, cycle_count, exp_cc);
    check_eq({tag, "_to_held"}, timed_out, exp_to);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_fin_stays"}, finished, 1);
    check_eq({tag, "_cc_stays"}, cycle_count, exp_cc);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    done_in        = 1'b0;
    bus.dump_ready = 1'b1;
    bus.mem_rdata  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    #12;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Basic run: done sampled 50 edges after start -> 46 RUN cycles.
    do_run("basic", 50, 32'd46, 1'b0, 12, -1);

    // Backpressure on word 2 adds 5 cycles; restart from DONE.
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;
    bp_arm = 1'b1;
    do_run("bp", 30, 32'd26, 1'b0, 17, -1);

    // Watchdog with done_in held low.
    mem[0] = 32'h5; mem[1] = 32'h6; mem[2] = 32'h7; mem[3] = 32'h8;
    do_run("wdog", 0, TOUT, 1'b1, 12, -1);

    // done_in edge in the same cycle the watchdog fires: edge wins.
    do_run("tie", int'(BOOT + TOUT), TOUT, 1'b0, 12, -1);

    // Reset during DUMP_OUT of word 1, then a clean run.
    do_run("abort", 20, 32'd16, 1'b0, 12, 1);
    mem[0] = 32'hC0FFEE; mem[1] = 32'h1; mem[2] = 32'hFFFF_FFFF; mem[3] = 32'h0;
    do_run("clean", 10, 32'd6, 1'b0, 12, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
